// File: rtl/irq_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: default sizes, FSM encodings, cfg_sel codes.
// Pure definitions; no logic, no latency, no backpressure.
package irq_arbiter_pkg;

    localparam int NSRC_DEF = 8;
    localparam int IDW_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic CFG_MASK = 1'b0;
    localparam logic CFG_CLR  = 1'b1;

endpackage

// File: rtl/irq_arbiter_prio_enc.sv
// Find-first-set over NSRC request bits; lowest index wins.
// Purely combinational, zero latency; no backpressure.
module prio_enc #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        idx = '0;
        // Scanning high to low lets the lowest set bit overwrite last.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDW'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/irq_arbiter.sv
// Edge-latching, maskable fixed-priority interrupt arbiter driving one level IRQ.
// Latency: edge to irq_out two clocks; ack/eoi take effect on the sampling edge; no backpressure.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic            cfg_we,
    input  logic            cfg_sel,
    input  logic [NSRC-1:0] cfg_wdata,
    input  logic            ack,
    input  logic            eoi,
    output logic            irq_out,
    output logic            active,
    output logic [IDW-1:0]  cause,
    output logic [NSRC-1:0] mask_q,
    output logic [NSRC-1:0] pending_q
);

    state_t          state_q, state_d;
    logic [NSRC-1:0] src_prev_q, src_prev_d;
    logic [NSRC-1:0] pending_d, mask_d;
    logic [IDW-1:0]  cause_q, cause_d;
    logic            irq_out_q, irq_out_d;
    logic            active_q, active_d;

    logic [NSRC-1:0] rise, eligible, clr, ack_clr;
    logic            win_vld;
    logic [IDW-1:0]  win_idx;

    assign rise     = src_irq & ~src_prev_q;
    assign eligible = pending_q & mask_q;

    prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio_enc (
        .req   (eligible),
        .valid (win_vld),
        .idx   (win_idx)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ack_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    cause_d = win_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // cause stays frozen here; a withdrawn source drops the request.
                if (ack) begin
                    ack_clr[cause_q] = 1'b1;
                    state_d          = ST_SERVICE;
                end else if (!eligible[cause_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        src_prev_d = src_irq;
        clr        = ack_clr;
        if (cfg_we && cfg_sel == CFG_CLR) begin
            clr = clr | cfg_wdata;
        end
        // A new edge in the same cycle as a clear must not be lost.
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = (cfg_we && cfg_sel == CFG_MASK) ? cfg_wdata : mask_q;
        irq_out_d = (state_d == ST_REQ);
        active_d  = (state_d == ST_SERVICE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            src_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            cause_q    <= '0;
            irq_out_q  <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_prev_q <= src_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            cause_q    <= cause_d;
            irq_out_q  <= irq_out_d;
            active_q   <= active_d;
        end
    end

    assign irq_out = irq_out_q;
    assign active  = active_q;
    assign cause   = cause_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed-vector bench for irq_arbiter: expected outputs queued per edge, checked by a monitor.
// Stimulus changes on the falling edge; the monitor samples 1 time unit after each rising edge.
module tb_irq_arbiter;

    logic       clock;
    logic       reset;
    logic [7:0] src_irq;
    logic       cfg_we;
    logic       cfg_sel;
    logic [7:0] cfg_wdata;
    logic       ack;
    logic       eoi;
    logic       irq_out;
    logic       active;
    logic [2:0] cause;
    logic [7:0] mask_q;
    logic [7:0] pending_q;

    typedef struct packed {
        logic        irq;
        logic        act;
        logic [2:0]  cause;
        logic [7:0]  mask;
        logic [7:0]  pend;
        logic [63:0] nm;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    irq_arbiter #(
        .NSRC (8),
        .IDW  (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .src_irq   (src_irq),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .ack       (ack),
        .eoi       (eoi),
        .irq_out   (irq_out),
        .active    (active),
        .cause     (cause),
        .mask_q    (mask_q),
        .pending_q (pending_q)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Set all non-reset inputs for the coming rising edge.
    task automatic drv(input logic [7:0] s, input logic we, input logic sel,
                       input logic [7:0] wd, input logic a, input logic e);
        src_irq   = s;
        cfg_we    = we;
        cfg_sel   = sel;
        cfg_wdata = wd;
        ack       = a;
        eoi       = e;
    endtask

    // Queue the outputs expected right after the next rising edge, then run that edge.
    task automatic cyc(input logic i, input logic a, input logic [2:0] c,
                       input logic [7:0] m, input logic [7:0] p, input logic [63:0] nm);
        exp_t e;
        e.irq   = i;
        e.act   = a;
        e.cause = c;
        e.mask  = m;
        e.pend  = p;
        e.nm    = nm;
        exp_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({irq_out, active, cause, mask_q, pending_q} !==
                    {e.irq, e.act, e.cause, e.mask, e.pend}) begin
                    bad++;
                    $display("FAIL %s: got irq=%b act=%b cause=%0d mask=%h pend=%h, want irq=%b act=%b cause=%0d mask=%h pend=%h",
                             e.nm, irq_out, active, cause, mask_q, pending_q,
                             e.irq, e.act, e.cause, e.mask, e.pend);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(0, 0, 0, 8'h00, 8'h00, "reset");
        reset = 1'b0;
        cyc(0, 0, 0, 8'h00, 8'h00, "quiet");

        // Masked source latches into pending but raises nothing until enabled.
        drv(8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 0, 0, 8'h00, 8'h08, "s3rise");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 0, 0, 8'h00, 8'h08, "s3mskd");
        drv(8'h00, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0); cyc(0, 0, 0, 8'h08, 8'h08, "mskwr08");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(1, 0, 3, 8'h08, 8'h08, "req3");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); cyc(0, 1, 3, 8'h08, 8'h00, "ack3");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); cyc(0, 0, 3, 8'h08, 8'h00, "eoi3");

        // Simultaneous rises on 5 and 2: lowest index first, then 5 after eoi.
        drv(8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0); cyc(0, 0, 3, 8'hFF, 8'h00, "mskFF");
        drv(8'h24, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 0, 3, 8'hFF, 8'h24, "s52rise");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(1, 0, 2, 8'hFF, 8'h24, "req2");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); cyc(0, 1, 2, 8'hFF, 8'h20, "ack2");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); cyc(0, 0, 2, 8'hFF, 8'h20, "eoi2idl");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(1, 0, 5, 8'hFF, 8'h20, "req5");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); cyc(0, 1, 5, 8'hFF, 8'h00, "ack5");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); cyc(0, 0, 5, 8'hFF, 8'h00, "eoi5");

        // Masking the requesting source withdraws the request.
        drv(8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 0, 5, 8'hFF, 8'h10, "s4rise");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(1, 0, 4, 8'hFF, 8'h10, "req4");
        drv(8'h00, 1'b1, 1'b0, 8'hEF, 1'b0, 1'b0); cyc(1, 0, 4, 8'hEF, 8'h10, "mskEF");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 0, 4, 8'hEF, 8'h10, "withdrw");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 0, 4, 8'hEF, 8'h10, "idle4");

        // Re-rise of the acked source in the ack cycle keeps its pending bit.
        drv(8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0); cyc(0, 0, 4, 8'h02, 8'h10, "msk02");
        drv(8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 0, 4, 8'h02, 8'h12, "s1rise");
        drv(8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(1, 0, 1, 8'h02, 8'h12, "req1");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(1, 0, 1, 8'h02, 8'h12, "req1hld");
        drv(8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); cyc(0, 1, 1, 8'h02, 8'h12, "ackrise");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); cyc(0, 0, 1, 8'h02, 8'h12, "eoi1");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(1, 0, 1, 8'h02, 8'h12, "req1b");

        // Stray acks and a full clear in service; ack with eoi takes eoi only.
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); cyc(0, 1, 1, 8'h02, 8'h10, "ack1b");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); cyc(0, 1, 1, 8'h02, 8'h10, "strayak");
        drv(8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0); cyc(0, 1, 1, 8'h02, 8'h00, "clrFF");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1); cyc(0, 0, 1, 8'h02, 8'h00, "ackeoi");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 0, 1, 8'h02, 8'h00, "noreq");

        // Reset in service, with a source held high across release.
        drv(8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0); cyc(0, 0, 1, 8'hFF, 8'h00, "mskFF2");
        drv(8'h0C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 0, 1, 8'hFF, 8'h0C, "s23rise");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(1, 0, 2, 8'hFF, 8'h0C, "req2b");
        drv(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); cyc(0, 1, 2, 8'hFF, 8'h08, "ack2b");
        drv(8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 1, 2, 8'hFF, 8'h0C, "svc0C");
        reset = 1'b1;
        drv(8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(0, 0, 0, 8'h00, 8'h00, "midrst");
        reset = 1'b0;
        cyc(0, 0, 0, 8'h00, 8'h01, "relrise");
        cyc(0, 0, 0, 8'h00, 8'h01, "held");
        drv(8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0); cyc(0, 0, 0, 8'h01, 8'h01, "msk01");
        drv(8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cyc(1, 0, 0, 8'h01, 8'h01, "req0");

        @(posedge clock);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
